// File: rtl/qnna_pkg.sv
// Shared constants for the QNNA MAC engine: register map, CSR bit layout,
// sequencer states and the PARAMS version tag.
package qnna_pkg;

    // Register and buffer offsets within the 4 KiB decoded window
    localparam logic [11:0] CTRL_ADDR   = 12'h000;
    localparam logic [11:0] STATUS_ADDR = 12'h004;
    localparam logic [11:0] DIM_K_ADDR  = 12'h008;
    localparam logic [11:0] PARAMS_ADDR = 12'h00C;
    localparam logic [11:0] X_BASE      = 12'h100;
    localparam logic [11:0] W_BASE      = 12'h400;
    localparam logic [11:0] Y_BASE      = 12'h800;

    // CTRL fields
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_RELU_BIT  = 1;
    localparam int CTRL_IRQ_BIT   = 2;
    localparam int CTRL_SHIFT_LSB = 8;
    localparam int SHIFT_W        = 5;

    // STATUS fields
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;
    localparam int STATUS_ERR_BIT  = 2;

    localparam logic [7:0] PARAMS_VERSION = 8'h02;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        REQ  = 2'd2
    } state_e;

endpackage

// File: rtl/qnna_lane.sv
// One output channel: signed INT8 MAC into an ACC_W accumulator, then
// arithmetic-shift requantisation, optional ReLU and saturation to INT8.
module qnna_lane
    import qnna_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               mac_en,
    input  logic               req,
    input  logic               relu_en,
    input  logic [SHIFT_W-1:0] shift,
    input  logic signed [7:0]  w,
    input  logic signed [7:0]  x,
    output logic signed [7:0]  y
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-128);

    logic signed [ACC_W-1:0] acc;
    logic signed [15:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] shifted;
    logic [SHIFT_W-1:0]      shamt;
    logic signed [7:0]       y_d;

    // Both operands are widened to 16 bits first so the product is exact.
    assign prod     = $signed({{8{w[7]}}, w}) * $signed({{8{x[7]}}, x});
    assign prod_ext = {{(ACC_W-16){prod[15]}}, prod};

    // Shifting by ACC_W-1 already leaves only the sign, so cap the amount there.
    assign shamt   = (int'(shift) > ACC_W - 1) ? SHIFT_W'(ACC_W - 1) : shift;
    assign shifted = acc >>> shamt;

    // Requantise: ReLU first, then clamp to the INT8 range.
    always_comb begin
        // NOTE: y_d gets a default before any branch so no path leaves it unassigned, which would infer a latch.
        y_d = shifted[7:0];
        if (relu_en && shifted[ACC_W-1]) begin
            y_d = 8'sh00;
        end else if (shifted > SAT_MAX) begin
            y_d = 8'sh7F;
        end else if (shifted < SAT_MIN) begin
            y_d = 8'sh80;
        end
    end

    // Accumulate during RUN, cleared when a run starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (mac_en) begin
            acc <= acc + prod_ext;
        end
    end

    // Result register, updated only in the REQ cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= '0;
        end else if (req) begin
            y <= y_d;
        end
    end

endmodule

// File: rtl/qnna_mac_engine.sv
// QNNA compute core: Wishbone slave with CSRs, X/W operand buffers, the
// IDLE/RUN/REQ sequencer and LANES parallel MAC lanes.
module qnna_mac_engine
    import qnna_pkg::*;
#(
    parameter int LANES = 4,
    parameter int MAX_K = 16,
    parameter int ACC_W = 24
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        irq_o
);

    localparam int XA_W = $clog2(MAX_K);
    localparam int WA_W = $clog2(LANES * MAX_K);
    localparam int LA_W = (LANES > 1) ? $clog2(LANES) : 1;

    // Operand buffers and lane results
    logic [7:0]        x_mem [MAX_K];
    logic [7:0]        w_mem [LANES*MAX_K];
    logic signed [7:0] y_vec [LANES];

    // CSRs
    logic               relu_en;
    logic               irq_en;
    logic [SHIFT_W-1:0] shift;
    logic [7:0]         dim_k;
    logic               done;
    logic               err_flag;

    // Sequencer
    state_e          state_q, state_d;
    logic [XA_W-1:0] k_q;
    logic            acc_clr, mac_en, req;

    // Bus decode
    logic [11:0]     adr;
    logic [XA_W-1:0] x_off;
    logic [WA_W-1:0] w_off;
    logic [LA_W-1:0] y_idx;
    logic is_ctrl, is_status, is_dim, is_params, is_x, is_w, is_y;
    logic access, busy, mapped, locked, bad, wr_ok, dim_ok, start_go;
    logic x_we, w_we;
    logic [31:0] rdata;
    logic unused_adr;

    assign unused_adr = &{1'b0, wb_adr_i[31:12], wb_adr_i[1:0]};

    assign adr   = {wb_adr_i[11:2], 2'b00};
    assign x_off = adr[XA_W-1:0];
    assign w_off = adr[WA_W-1:0];
    assign y_idx = adr[LA_W+1:2];

    assign is_ctrl   = (adr == CTRL_ADDR);
    assign is_status = (adr == STATUS_ADDR);
    assign is_dim    = (adr == DIM_K_ADDR);
    assign is_params = (adr == PARAMS_ADDR);
    assign is_x      = (adr >= X_BASE) && (adr < X_BASE + 12'(MAX_K));
    assign is_w      = (adr >= W_BASE) && (adr < W_BASE + 12'(LANES * MAX_K));
    assign is_y      = (adr >= Y_BASE) && (adr < Y_BASE + 12'(4 * LANES));

    // A new access is one not already being answered this cycle.
    assign access = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign busy   = (state_q != IDLE);
    assign mapped = is_ctrl | is_status | is_dim | is_params | is_x | is_w | is_y;
    assign locked = wb_we_i & busy & (is_ctrl | is_dim | is_x | is_w);
    assign bad    = ~mapped | locked;
    assign wr_ok  = access & wb_we_i & ~bad;
    assign x_we   = wr_ok & is_x;
    assign w_we   = wr_ok & is_w;

    assign dim_ok   = (dim_k != 8'd0) && ({1'b0, dim_k} <= 9'(MAX_K));
    assign start_go = wr_ok & is_ctrl & wb_dat_i[CTRL_START_BIT] & dim_ok;

    assign irq_o = done & irq_en;

    // Read-data mux for the addressed register or buffer word.
    always_comb begin
        rdata = '0;
        if (is_ctrl) begin
            rdata[CTRL_RELU_BIT]                    = relu_en;
            rdata[CTRL_IRQ_BIT]                     = irq_en;
            rdata[CTRL_SHIFT_LSB +: SHIFT_W]        = shift;
        end else if (is_status) begin
            rdata[STATUS_BUSY_BIT] = busy;
            rdata[STATUS_DONE_BIT] = done;
            rdata[STATUS_ERR_BIT]  = err_flag;
        end else if (is_dim) begin
            rdata = {24'd0, dim_k};
        end else if (is_params) begin
            rdata = {8'(ACC_W), 8'(MAX_K), 8'(LANES), PARAMS_VERSION};
        end else if (is_x) begin
            rdata = {x_mem[x_off + XA_W'(3)], x_mem[x_off + XA_W'(2)],
                     x_mem[x_off + XA_W'(1)], x_mem[x_off]};
        end else if (is_w) begin
            rdata = {w_mem[w_off + WA_W'(3)], w_mem[w_off + WA_W'(2)],
                     w_mem[w_off + WA_W'(1)], w_mem[w_off]};
        end else if (is_y) begin
            rdata = {{24{y_vec[y_idx][7]}}, y_vec[y_idx]};
        end
    end

    // Bus response and CSR updates.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
            relu_en  <= 1'b0;
            irq_en   <= 1'b0;
            shift    <= '0;
            dim_k    <= '0;
            done     <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            wb_ack_o <= access & ~bad;
            wb_err_o <= access & bad;
            wb_dat_o <= (access & ~bad & ~wb_we_i) ? rdata : '0;

            if (wr_ok && is_ctrl) begin
                relu_en <= wb_dat_i[CTRL_RELU_BIT];
                irq_en  <= wb_dat_i[CTRL_IRQ_BIT];
                shift   <= wb_dat_i[CTRL_SHIFT_LSB +: SHIFT_W];
                if (wb_dat_i[CTRL_START_BIT] && !dim_ok) begin
                    err_flag <= 1'b1;
                end
            end
            if (wr_ok && is_dim) begin
                dim_k <= wb_dat_i[7:0];
            end
            if (wr_ok && is_status) begin
                if (wb_dat_i[STATUS_DONE_BIT]) done     <= 1'b0;
                if (wb_dat_i[STATUS_ERR_BIT])  err_flag <= 1'b0;
            end
            // Later assignments win: a REQ completing overrides a same-cycle W1C.
            if (acc_clr) done <= 1'b0;
            if (req)     done <= 1'b1;
        end
    end

    // Byte-enabled operand buffer writes.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: the buffers have no reset; software must load them before use, and this keeps them plain RAM.
        for (int b = 0; b < 4; b++) begin
            if (x_we && wb_sel_i[b]) x_mem[x_off + XA_W'(b)] <= wb_dat_i[8*b +: 8];
            if (w_we && wb_sel_i[b]) w_mem[w_off + WA_W'(b)] <= wb_dat_i[8*b +: 8];
        end
    end

    // Sequencer state register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next-state and lane controls.
    always_comb begin
        state_d = state_q;
        acc_clr = 1'b0;
        mac_en  = 1'b0;
        req     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_go) begin
                    acc_clr = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                mac_en = 1'b1;
                if (8'(k_q) == dim_k - 8'd1) state_d = REQ;
            end
            REQ: begin
                req     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reduction index: reset on run entry, stepped by each MAC cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            k_q <= '0;
        end else if (acc_clr) begin
            k_q <= '0;
        end else if (mac_en) begin
            k_q <= k_q + XA_W'(1);
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [WA_W-1:0] w_idx;
        assign w_idx = WA_W'(g * MAX_K) + WA_W'(k_q);

        qnna_lane #(.ACC_W(ACC_W)) u_lane (
            .clk     (wb_clk_i),
            .rst_n   (wb_rst_ni),
            .clr     (acc_clr),
            .mac_en  (mac_en),
            .req     (req),
            .relu_en (relu_en),
            .shift   (shift),
            .w       ($signed(w_mem[w_idx])),
            .x       ($signed(x_mem[k_q])),
            .y       (y_vec[g])
        );
    end

endmodule

// File: tb/tb_qnna_mac_engine.sv
// Directed self-checking bench for qnna_mac_engine (LANES=4, MAX_K=16, ACC_W=24).
module tb_qnna_mac_engine;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_we_i = 1'b0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] C_START = 32'h1;
    localparam logic [31:0] C_RELU  = 32'h2;
    localparam logic [31:0] C_IRQ   = 32'h4;

    qnna_mac_engine #(.LANES(4), .MAX_K(16), .ACC_W(24)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_ni(wb_rst_ni),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_we_i  (wb_we_i),
        .wb_sel_i (wb_sel_i),
        .wb_stb_i (wb_stb_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .irq_o    (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One classic Wishbone access; returns whichever of ack/err arrives first.
    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                       input logic [3:0] sel, output logic [31:0] rdat,
                       output logic ack, output logic err);
        @(negedge wb_clk_i);
        wb_adr_i = adr; wb_dat_i = wdat; wb_sel_i = sel; wb_we_i = we;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        ack = 1'b0; err = 1'b0; rdat = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge wb_clk_i); #1;
            if (wb_ack_o || wb_err_o) begin
                ack = wb_ack_o; err = wb_err_o; rdat = wb_dat_o;
                break;
            end
        end
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wr_sel(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] rd; logic ack; logic err;
        bus(1'b1, adr, dat, sel, rd, ack, err);
        check("wr_ack", {31'd0, ack}, 32'd1);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        wr_sel(adr, dat, 4'hF);
    endtask

    task automatic rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] rdat; logic ack; logic err;
        bus(1'b0, adr, 32'd0, 4'hF, rdat, ack, err);
        check({tag, "_ack"}, {31'd0, ack}, 32'd1);
        check(tag, rdat, exp);
    endtask

    task automatic expect_err(input string tag, input logic we, input logic [31:0] adr);
        logic [31:0] rdat; logic ack; logic err;
        bus(we, adr, 32'h0, 4'hF, rdat, ack, err);
        check(tag, {30'd0, ack, err}, 32'd1);
    endtask

    task automatic fill(input logic [31:0] base, input logic [31:0] val);
        for (int j = 0; j < 4; j++) wr(base + 32'(4 * j), val);
    endtask

    // Waits for irq_o (IRQ_EN is always set with START); n is the edge count, 0 on timeout.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        for (int i = 1; i <= 64; i++) begin
            @(posedge wb_clk_i); #1;
            if (irq_o) begin n = i; break; end
        end
        check(tag, {31'd0, n != 0}, 32'd1);
    endtask

    initial begin
        int n;

        // Reset values
        #1;
        check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check("rst_err", {31'd0, wb_err_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        rd("rst_ctrl",   32'h000, 32'h0);
        rd("rst_status", 32'h004, 32'h0);
        rd("rst_dimk",   32'h008, 32'h0);
        rd("rst_y0",     32'h800, 32'h0);
        rd("params",     32'h00C, 32'h1810_0402);

        // Basic 4-deep dot products and latency
        wr(32'h100, 32'h0403_0201);
        wr(32'h400, 32'h0101_0101);
        wr(32'h410, 32'hFFFF_FFFF);
        wr(32'h008, 32'd4);
        wr(32'h000, C_START | C_IRQ);
        wait_done("done_k4", n);
        check("done_latency", 32'(n), 32'd5);
        rd("k4_y0", 32'h800, 32'h0000_000A);
        rd("k4_y1", 32'h804, 32'hFFFF_FFF6);
        rd("k4_status", 32'h004, 32'h2);
        rd("k4_ctrl", 32'h000, 32'h4);
        wr(32'h004, 32'h2);
        #1;
        check("irq_cleared", {31'd0, irq_o}, 32'd0);

        wr(32'h000, C_START | C_RELU | C_IRQ);
        wait_done("done_relu", n);
        rd("relu_y0", 32'h800, 32'h0000_000A);
        rd("relu_y1", 32'h804, 32'h0000_0000);

        // Full-depth saturation and shift
        fill(32'h100, 32'h7F7F_7F7F);
        fill(32'h400, 32'h7F7F_7F7F);
        wr(32'h008, 32'd16);
        wr(32'h000, C_START | C_IRQ);
        wait_done("done_sat", n);
        rd("sat_hi_y0", 32'h800, 32'h0000_007F);
        wr(32'h000, C_START | C_IRQ | (32'd12 << 8));
        wait_done("done_shift", n);
        rd("shift12_y0", 32'h800, 32'h0000_003F);
        fill(32'h100, 32'h8080_8080);
        wr(32'h000, C_START | C_IRQ);
        wait_done("done_neg", n);
        rd("sat_lo_y0", 32'h800, 32'hFFFF_FF80);

        // Accesses during a run
        fill(32'h100, 32'h7F7F_7F7F);
        wr(32'h000, C_START | C_IRQ | (32'd12 << 8));
        expect_err("busy_w_write", 1'b1, 32'h400);
        rd("busy_status", 32'h004, 32'h1);
        expect_err("unmapped_ffc", 1'b0, 32'hFFC);
        wait_done("done_busy", n);
        rd("busy_y0", 32'h800, 32'h0000_003F);
        rd("busy_w_kept", 32'h400, 32'h7F7F_7F7F);
        expect_err("x_beyond", 1'b0, 32'h110);
        expect_err("y_beyond", 1'b0, 32'h810);

        // Invalid DIM_K
        wr(32'h004, 32'h2);
        wr(32'h008, 32'd0);
        wr(32'h000, C_START | C_IRQ);
        rd("dimk0_status", 32'h004, 32'h4);
        wr(32'h004, 32'h4);
        rd("err_w1c", 32'h004, 32'h0);
        wr(32'h008, 32'd17);
        wr(32'h000, C_START | C_IRQ);
        rd("dimk17_status", 32'h004, 32'h4);
        wr(32'h004, 32'h4);

        // Reset in the middle of a run
        wr(32'h008, 32'd16);
        wr(32'h000, C_START | C_IRQ);
        repeat (3) @(posedge wb_clk_i);
        #2;
        wb_rst_ni = 1'b0;
        #1;
        check("arst_ack", {31'd0, wb_ack_o}, 32'd0);
        check("arst_err", {31'd0, wb_err_o}, 32'd0);
        check("arst_dat", wb_dat_o, 32'd0);
        check("arst_irq", {31'd0, irq_o}, 32'd0);
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        rd("arst_status", 32'h004, 32'h0);
        rd("arst_y0", 32'h800, 32'h0);
        fill(32'h100, 32'h7F7F_7F7F);
        fill(32'h400, 32'h7F7F_7F7F);
        wr(32'h008, 32'd16);
        wr(32'h000, C_START | C_IRQ | (32'd12 << 8));
        wait_done("done_after_rst", n);
        rd("after_rst_y0", 32'h800, 32'h0000_003F);

        // Byte-enabled X write
        wr(32'h100, 32'h0403_0201);
        wr(32'h400, 32'h0101_0101);
        wr(32'h410, 32'hFFFF_FFFF);
        wr_sel(32'h100, 32'h0000_0500, 4'b0010);
        rd("sel_x0", 32'h100, 32'h0403_0501);
        wr(32'h008, 32'd4);
        wr(32'h000, C_START | C_IRQ);
        wait_done("done_sel", n);
        rd("sel_y0", 32'h800, 32'h0000_000D);
        rd("sel_y1", 32'h804, 32'hFFFF_FFF3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
